// File: rtl/regbank_reader.sv
//------------------------------------------------------------------------------
// Module   : regbank_reader
// Brief    : DEPTH x W register bank with decoded write port and a burst
//            read engine streaming words over valid/ready, tagged by index.
// Options  : REGBANK_READER_BYPASS_EN forwards a same-cycle write into a load.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regbank_reader #(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int SW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [SW-1:0] sel,
    input  logic [W-1:0]  wd,
    input  logic          start,
    input  logic [SW-1:0] start_idx,
    input  logic [SW:0]   count,
    input  logic          abort,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [W-1:0]  rd_data,
    output logic [SW-1:0] rd_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic [SW:0] DEPTH_W = (SW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW:0]   rem_q, rem_d;
    logic          rd_valid_q, rd_valid_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic [SW-1:0] rd_idx_q, rd_idx_d;
    logic          done_q, done_d;

    logic [SW-1:0] ptr_inc;
    logic [SW-1:0] load_idx;
    logic [W-1:0]  load_data;

    assign ptr_inc  = ptr_q + SW'(1);
    // In SEND the only load is the word after the one being handed off.
    assign load_idx = (state_q == SEND) ? ptr_inc : ptr_q;

`ifdef REGBANK_READER_BYPASS_EN
    assign load_data = (wr_en && (sel == load_idx)) ? wd : mem_q[load_idx];
`else
    assign load_data = mem_q[load_idx];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[sel] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_idx_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_idx_q   <= rd_idx_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_idx_d   = rd_idx_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        ptr_d   = start_idx;
                        rem_d   = (count > DEPTH_W) ? DEPTH_W : count;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    rd_data_d  = load_data;
                    rd_idx_d   = load_idx;
                    rd_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // Abort wins over a same-cycle handshake.
                if (abort) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (rd_valid_q && rd_ready) begin
                    if (rem_q > (SW+1)'(1)) begin
                        ptr_d     = ptr_inc;
                        rem_d     = rem_q - (SW+1)'(1);
                        rd_data_d = load_data;
                        rd_idx_d  = load_idx;
                    end else begin
                        rd_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                rd_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_idx   = rd_idx_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

`default_nettype wire
